// File: rtl/x_mux_n_to_1_scan_if.sv
// Bus bundle for the N-to-1 scanning multiplexer.
// The master side drives channel data and control; the slave side (the mux)
// returns the registered selection, its index and the scan status flags.
interface x_mux_n_to_1_scan_if #(
  parameter int N       = 8,
  parameter int W       = 1,
  parameter int DWELL_W = 8,
  parameter int IW      = $clog2(N)
);
  logic [N*W-1:0]     i_data;
  logic               i_mode;
  logic [IW-1:0]      i_sel;
  logic [DWELL_W-1:0] i_dwell;
  logic               i_start;
  logic               i_stop;
  logic [W-1:0]       o_y;
  logic [IW-1:0]      o_idx;
  logic               o_wrap;
  logic               o_busy;

  modport master (
    output i_data, i_mode, i_sel, i_dwell, i_start, i_stop,
    input  o_y, o_idx, o_wrap, o_busy
  );

  modport slave (
    input  i_data, i_mode, i_sel, i_dwell, i_start, i_stop,
    output o_y, o_idx, o_wrap, o_busy
  );
endinterface

// File: rtl/x_mux_n_to_1_scan.sv
// N-to-1 multiplexer of W-bit channels with a registered output.
// Direct mode forwards the channel named by i_sel. Scan mode walks the
// channels round-robin, holding each for (latched dwell + 1) cycles and
// pulsing o_wrap when the index rolls over from N-1 back to 0.
// Out-of-range direct indices (only possible when N is not a power of two)
// yield an all-zero output while o_idx still reports the raw index.
module x_mux_n_to_1_scan #(
  parameter int N       = 8,
  parameter int W       = 1,
  parameter int DWELL_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  x_mux_n_to_1_scan_if.slave      bus
);

  localparam int IW = $clog2(N);

  localparam logic [IW-1:0]      IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0]      IDX_ONE  = IW'(1);
  localparam logic [IW-1:0]      IDX_LAST = IW'(N - 1);
  localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0] CNT_ONE  = DWELL_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [IW-1:0]      idx_r, idx_s;
  logic [W-1:0]       y_r, y_s;
  logic               wrap_r, wrap_s;
  logic               busy_r, busy_s;
  logic [DWELL_W-1:0] cnt_r, cnt_s;
  logic [DWELL_W-1:0] dwell_lat_r, dwell_lat_s;

  // AND-OR channel select; an index with no matching channel produces zero.
  function automatic logic [W-1:0] pick_channel(
    input logic [N*W-1:0] data,
    input logic [IW-1:0]  idx
  );
    logic [W-1:0] sel_y;
    sel_y = {W{1'b0}};
    for (int c = 0; c < N; c++) begin
      sel_y = sel_y | (data[c*W +: W] & {W{idx == IW'(c)}});
    end
    return sel_y;
  endfunction

  // Next-state, next-index and dwell counter decisions for both states.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    cnt_s       = cnt_r;
    dwell_lat_s = dwell_lat_r;
    wrap_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_start && bus.i_mode && !bus.i_stop) begin
          state_s     = ST_SCAN;
          idx_s       = IDX_ZERO;
          cnt_s       = bus.i_dwell;
          dwell_lat_s = bus.i_dwell;
        end else begin
          idx_s = bus.i_sel;
        end
      end
      ST_SCAN: begin
        if (bus.i_stop || !bus.i_mode) begin
          // Leaving scan behaves exactly like an IDLE edge: follow i_sel now.
          state_s = ST_IDLE;
          idx_s   = bus.i_sel;
        end else if (bus.i_start) begin
          idx_s       = IDX_ZERO;
          cnt_s       = bus.i_dwell;
          dwell_lat_s = bus.i_dwell;
        end else if (cnt_r == CNT_ZERO) begin
          idx_s  = (idx_r == IDX_LAST) ? IDX_ZERO : (idx_r + IDX_ONE);
          cnt_s  = dwell_lat_r;
          wrap_s = (idx_r == IDX_LAST);
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = IDX_ZERO;
      end
    endcase
  end

  // Output data follows the index chosen for this edge, from live i_data.
  always_comb begin
    y_s    = pick_channel(bus.i_data, idx_s);
    busy_s = (state_s == ST_SCAN);
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      idx_r       <= IDX_ZERO;
      y_r         <= {W{1'b0}};
      wrap_r      <= 1'b0;
      busy_r      <= 1'b0;
      cnt_r       <= CNT_ZERO;
      dwell_lat_r <= CNT_ZERO;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      y_r         <= y_s;
      wrap_r      <= wrap_s;
      busy_r      <= busy_s;
      cnt_r       <= cnt_s;
      dwell_lat_r <= dwell_lat_s;
    end
  end

  assign bus.o_y    = y_r;
  assign bus.o_idx  = idx_r;
  assign bus.o_wrap = wrap_r;
  assign bus.o_busy = busy_r;

endmodule

// File: tb/tb_x_mux_n_to_1_scan.sv
// Scoreboard bench for x_mux_n_to_1_scan. Three instances cover N=8/W=4,
// N=4/W=8 and a non-power-of-two N=5/W=4. Stimulus pushes hand-computed
// expectations into a queue; a monitor pops and compares them on the
// falling clock edge (or immediately on request for the async reset check).
module tb_x_mux_n_to_1_scan;

  logic clk;
  logic rst;

  x_mux_n_to_1_scan_if #(.N(8), .W(4), .DWELL_W(8)) bus_a ();
  x_mux_n_to_1_scan_if #(.N(4), .W(8), .DWELL_W(8)) bus_b ();
  x_mux_n_to_1_scan_if #(.N(5), .W(4), .DWELL_W(8)) bus_c ();

  x_mux_n_to_1_scan #(.N(8), .W(4), .DWELL_W(8)) u_dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_a.slave)
  );

  x_mux_n_to_1_scan #(.N(4), .W(8), .DWELL_W(8)) u_dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_b.slave)
  );

  x_mux_n_to_1_scan #(.N(5), .W(4), .DWELL_W(8)) u_dut_c (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_c.slave)
  );

  typedef struct {
    int         dut;
    logic [7:0] y;
    logic [7:0] idx;
    logic       wrap;
    logic       busy;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  event mon_ev;

  logic [7:0] chan_b [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [7:0] chan_a [8] = '{8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input int dut, input logic [7:0] y, input logic [7:0] idx,
                          input logic wrap, input logic busy, input string name);
    exp_t e;
    e.dut  = dut;
    e.y    = y;
    e.idx  = idx;
    e.wrap = wrap;
    e.busy = busy;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued expectation against the addressed DUT.
  initial begin
    forever begin
      @(negedge clk or mon_ev);
      while (exp_q.size() > 0) begin
        exp_t       e;
        logic [7:0] act_y;
        logic [7:0] act_idx;
        logic       act_wrap;
        logic       act_busy;
        e = exp_q.pop_front();
        case (e.dut)
          0: begin
            act_y = {4'h0, bus_a.o_y}; act_idx = {5'd0, bus_a.o_idx};
            act_wrap = bus_a.o_wrap;   act_busy = bus_a.o_busy;
          end
          1: begin
            act_y = bus_b.o_y;         act_idx = {6'd0, bus_b.o_idx};
            act_wrap = bus_b.o_wrap;   act_busy = bus_b.o_busy;
          end
          default: begin
            act_y = {4'h0, bus_c.o_y}; act_idx = {5'd0, bus_c.o_idx};
            act_wrap = bus_c.o_wrap;   act_busy = bus_c.o_busy;
          end
        endcase
        checks++;
        if (act_y !== e.y || act_idx !== e.idx || act_wrap !== e.wrap || act_busy !== e.busy) begin
          errors++;
          $display("FAIL %s: got y=%h idx=%0d wrap=%b busy=%b, expected y=%h idx=%0d wrap=%b busy=%b",
                   e.name, act_y, act_idx, act_wrap, act_busy, e.y, e.idx, e.wrap, e.busy);
        end
      end
    end
  end

  // Stimulus: directed vectors with hand-computed expectations.
  initial begin
    rst = 1'b1;
    bus_a.i_data = {4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
    bus_a.i_mode = 1'b0; bus_a.i_sel = 3'd0; bus_a.i_dwell = 8'd0;
    bus_a.i_start = 1'b0; bus_a.i_stop = 1'b0;
    bus_b.i_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    bus_b.i_mode = 1'b0; bus_b.i_sel = 2'd0; bus_b.i_dwell = 8'd0;
    bus_b.i_start = 1'b0; bus_b.i_stop = 1'b0;
    bus_c.i_data = {4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
    bus_c.i_mode = 1'b0; bus_c.i_sel = 3'd0; bus_c.i_dwell = 8'd0;
    bus_c.i_start = 1'b0; bus_c.i_stop = 1'b0;

    // Reset state of every instance.
    #1;
    push_exp(0, 8'h00, 8'd0, 1'b0, 1'b0, "reset_a");
    push_exp(1, 8'h00, 8'd0, 1'b0, 1'b0, "reset_b");
    push_exp(2, 8'h00, 8'd0, 1'b0, 1'b0, "reset_c");
    tick();
    rst = 1'b0;

    // Direct mode, N=4 W=8.
    bus_b.i_sel = 2'd2;
    tick(); push_exp(1, 8'hCC, 8'd2, 1'b0, 1'b0, "direct_sel2");
    bus_b.i_sel = 2'd0;
    tick(); push_exp(1, 8'hAA, 8'd0, 1'b0, 1'b0, "direct_sel0");

    // Non-power-of-two N=5: out-of-range indices give zero data.
    bus_c.i_sel = 3'd6;
    tick(); push_exp(2, 8'h00, 8'd6, 1'b0, 1'b0, "nonpow2_sel6");
    bus_c.i_sel = 3'd4;
    tick(); push_exp(2, 8'h05, 8'd4, 1'b0, 1'b0, "nonpow2_sel4");
    bus_c.i_sel = 3'd7;
    tick(); push_exp(2, 8'h00, 8'd7, 1'b0, 1'b0, "nonpow2_sel7");

    // Scan N=4, dwell=2: each channel held 3 cycles, wrap on return to 0.
    bus_b.i_mode = 1'b1; bus_b.i_dwell = 8'd2; bus_b.i_sel = 2'd3; bus_b.i_start = 1'b1;
    tick(); push_exp(1, 8'hAA, 8'd0, 1'b0, 1'b1, "scan_start");
    bus_b.i_start = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      int ix;
      ix = (k / 3) % 4;
      tick(); push_exp(1, chan_b[ix], 8'(ix), (k == 12), 1'b1, $sformatf("scan_step%0d", k));
    end

    // Restart at index 2 returns to channel 0.
    bus_b.i_start = 1'b1;
    tick(); push_exp(1, 8'hAA, 8'd0, 1'b0, 1'b1, "restart_idx0");
    bus_b.i_start = 1'b0;
    tick(); push_exp(1, 8'hAA, 8'd0, 1'b0, 1'b1, "restart_hold");

    // Stop beats start in the same cycle.
    bus_b.i_sel = 2'd1; bus_b.i_stop = 1'b1; bus_b.i_start = 1'b1;
    tick(); push_exp(1, 8'hBB, 8'd1, 1'b0, 1'b0, "stop_beats_start");
    bus_b.i_stop = 1'b0; bus_b.i_start = 1'b0;
    tick(); push_exp(1, 8'hBB, 8'd1, 1'b0, 1'b0, "idle_after_stop");

    // Dwell 0 steps every cycle; a mid-scan dwell change is ignored.
    bus_b.i_dwell = 8'd0; bus_b.i_start = 1'b1;
    tick(); push_exp(1, 8'hAA, 8'd0, 1'b0, 1'b1, "dwell0_start");
    bus_b.i_start = 1'b0; bus_b.i_dwell = 8'd5;
    for (int k = 1; k <= 5; k++) begin
      tick(); push_exp(1, chan_b[k % 4], 8'(k % 4), (k == 4), 1'b1, $sformatf("dwell0_step%0d", k));
    end
    bus_b.i_mode = 1'b0; bus_b.i_sel = 2'd3;
    tick(); push_exp(1, 8'hDD, 8'd3, 1'b0, 1'b0, "mode_drop");

    // Async reset mid-scan on N=8 W=4.
    bus_a.i_mode = 1'b1; bus_a.i_dwell = 8'd1; bus_a.i_start = 1'b1;
    tick(); push_exp(0, 8'h08, 8'd0, 1'b0, 1'b1, "a_scan_start");
    bus_a.i_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick(); push_exp(0, chan_a[k / 2], 8'(k / 2), 1'b0, 1'b1, $sformatf("a_scan_step%0d", k));
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    push_exp(0, 8'h00, 8'd0, 1'b0, 1'b0, "async_reset_midscan");
    -> mon_ev;
    #1;
    tick(); push_exp(0, 8'h00, 8'd0, 1'b0, 1'b0, "reset_held");
    rst = 1'b0; bus_a.i_mode = 1'b0; bus_a.i_sel = 3'd5;
    tick(); push_exp(0, 8'h0D, 8'd5, 1'b0, 1'b0, "after_reset_direct");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
